// File: rtl/grade_digito_amostrador.sv
// 11x11 box-averaging digit-grid sampler over a fixed ROI of a raster luma stream.
// Optional GRADE_INVERTE_EN: accumulate 255-pix_luma instead of pix_luma.
module grade_digito_amostrador #(
   parameter int ROI_X0      = 160,
   parameter int ROI_Y0      = 120,
   parameter int CELL_W_LOG2 = 3,
   parameter int CELL_H_LOG2 = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    frame_start,
   input  logic                    pix_valid,
   input  logic [9:0]              pix_x,
   input  logic [9:0]              pix_y,
   input  logic [7:0]              pix_luma,
   output logic                    busy,
   output logic                    grid_valid,
   output logic [10:0][10:0][7:0]  numero
);

   localparam int N     = 11;
   localparam int SHIFT = CELL_W_LOG2 + CELL_H_LOG2;
   localparam int ACC_W = 8 + SHIFT;
   localparam logic [9:0] X0_C = 10'(ROI_X0);
   localparam logic [9:0] Y0_C = 10'(ROI_Y0);
   localparam logic [9:0] W_C  = 10'(N << CELL_W_LOG2);
   localparam logic [9:0] H_C  = 10'(N << CELL_H_LOG2);
   localparam logic [9:0] CW_M = 10'((1 << CELL_W_LOG2) - 1);
   localparam logic [9:0] CH_M = 10'((1 << CELL_H_LOG2) - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [9:0]        dx_s;
   logic [9:0]        dy_s;
   logic              in_roi_s;
   logic [3:0]        col_s;
   logic [3:0]        row_s;
   logic [7:0]        lum_s;
   logic              restart_s;
   logic              accept_s;
   logic              close_s;
   logic              pub_s;
   logic [ACC_W-1:0]  acc_sel_s;
   logic [ACC_W-1:0]  sum_s;
   logic [7:0]        avg_s;
   logic [ACC_W-1:0]  acc_r  [N];
   logic [7:0]        work_r [N][N];

   // Pixel decode: ROI offset, cell indices, acceptance and running cell sum.
   always_comb begin
      dx_s      = pix_x - X0_C;
      dy_s      = pix_y - Y0_C;
      // Offsets left/above the ROI wrap to large values, so one compare covers both edges.
      in_roi_s  = (dx_s < W_C) && (dy_s < H_C);
      col_s     = 4'(dx_s >> CELL_W_LOG2);
      row_s     = 4'(dy_s >> CELL_H_LOG2);
`ifdef GRADE_INVERTE_EN
      lum_s     = 8'd255 - pix_luma;
`else
      lum_s     = pix_luma;
`endif
      restart_s = frame_start && ((state_r == WAIT_FRAME) || (state_r == CAPTURE));
      accept_s  = pix_valid && in_roi_s && ((state_r == CAPTURE) || restart_s);
      close_s   = accept_s && ((dx_s & CW_M) == CW_M) && ((dy_s & CH_M) == CH_M);
      pub_s     = accept_s && (state_r == CAPTURE) && !restart_s &&
                  (dx_s == W_C - 10'd1) && (dy_s == H_C - 10'd1);
      acc_sel_s = '0;
      for (int c = 0; c < N; c++) begin
         acc_sel_s = (col_s == 4'(c)) ? acc_r[c] : acc_sel_s;
      end
      sum_s     = (restart_s ? {ACC_W{1'b0}} : acc_sel_s) + ACC_W'(lum_s);
      avg_s     = 8'(sum_s >> SHIFT);
   end

   // Next-state logic of the capture sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = WAIT_FRAME;
            else       state_next_s = IDLE;
         end
         WAIT_FRAME: begin
            if (frame_start) state_next_s = CAPTURE;
            else             state_next_s = WAIT_FRAME;
         end
         CAPTURE: begin
            if (pub_s) state_next_s = DONE;
            else       state_next_s = CAPTURE;
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         busy       <= 1'b0;
         grid_valid <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         busy       <= (state_next_s == WAIT_FRAME) || (state_next_s == CAPTURE);
         grid_valid <= pub_s;
      end
   end

   // Per-column accumulators; a closing cell hands its sum over and restarts at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < N; c++) acc_r[c] <= '0;
      end else begin
         for (int c = 0; c < N; c++) begin
            if (accept_s && (col_s == 4'(c))) acc_r[c] <= close_s ? {ACC_W{1'b0}} : sum_s;
            else if (restart_s)               acc_r[c] <= '0;
         end
      end
   end

   // Working grid: cleared at the start of each capture, filled as cells close.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) work_r[r][c] <= 8'd0;
      end else begin
         if (restart_s) begin
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++) work_r[r][c] <= 8'd0;
         end
         if (close_s) work_r[row_s][col_s] <= avg_s;
      end
   end

   // Published grid; the final cell is forwarded directly since it closes on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         numero <= '0;
      end else if (pub_s) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) numero[r][c] <= work_r[r][c];
         numero[N-1][N-1] <= avg_s;
      end
   end

endmodule
